// File: rtl/b08_search.sv
// b08_search: scans candidate patterns 0x00..0xFF in ascending order and returns the
// smallest one whose OR of matching b08 ROM codes equals the target class.
module b08_search (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] T,
  output logic [7:0] I_OUT,
  output logic       FOUND,
  output logic       DONE,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  t_r;
  logic [7:0]  cand;
  logic [2:0]  mar;
  logic [3:0]  acc;

  logic [19:0] rom_word;
  logic [7:0]  r1;
  logic [7:0]  r2;
  logic [3:0]  code;
  logic        hit;
  logic [3:0]  nxt;

  always_comb begin
    rom_word = 20'h0_0000;
    case (mar)
      3'd0: rom_word = 20'h7F97A;
      3'd1: rom_word = 20'h39D62;
      3'd2: rom_word = 20'hA8FFF;
      3'd3: rom_word = 20'hFF6BA;
      3'd4: rom_word = 20'hFFF6E;
      3'd5: rom_word = 20'hFFBA8;
      3'd6: rom_word = 20'hCA75B;
      3'd7: rom_word = 20'h2FFF4;
      default: rom_word = 20'h0_0000;
    endcase
  end

  assign r1   = rom_word[19:12];
  assign r2   = rom_word[11:4];
  assign code = rom_word[3:0];
  assign hit  = (((r2 & ~cand) | (r1 & cand) | (r2 & r1)) == 8'hFF);
  // Class accumulated so far for this candidate, including the entry at mar
  assign nxt  = acc | (hit ? code : 4'h0);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= S_IDLE;
      t_r   <= 4'h0;
      cand  <= 8'h00;
      mar   <= 3'd0;
      acc   <= 4'h0;
      I_OUT <= 8'h00;
      FOUND <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_LOAD;
            BUSY  <= 1'b1;
          end
        end
        S_LOAD: begin
          t_r   <= T;
          cand  <= 8'h00;
          mar   <= 3'd0;
          acc   <= 4'h0;
          FOUND <= 1'b0;
          I_OUT <= 8'h00;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (mar != 3'd7) begin
            acc <= nxt;
            mar <= mar + 3'd1;
          end else if (nxt == t_r) begin
            I_OUT <= cand;
            FOUND <= 1'b1;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_DONE;
          end else if (cand == 8'hFF) begin
            // Last candidate exhausted without a hit; the candidate never wraps
            I_OUT <= 8'h00;
            FOUND <= 1'b0;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_DONE;
          end else begin
            cand <= cand + 8'd1;
            mar  <= 3'd0;
            acc  <= 4'h0;
          end
        end
        S_DONE: begin
          if (!START) begin
            DONE  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b08_search.sv
// Directed self-checking bench for b08_search: search results, edge timing,
// mid-search disturbances and the DONE handshake.
module tb_b08_search;

  logic       CLOCK;
  logic       RESET;
  logic       START;
  logic [3:0] T;
  logic [7:0] I_OUT;
  logic       FOUND;
  logic       DONE;
  logic       BUSY;

  int total = 0;
  int bad   = 0;
  int n;
  logic busy_ok;
  logic stable_ok;

  b08_search dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .START(START),
    .T(T),
    .I_OUT(I_OUT),
    .FOUND(FOUND),
    .DONE(DONE),
    .BUSY(BUSY)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the edge index (counted from 1 after the call) at which DONE rose, or -1
  // on timeout; busy_o reports whether BUSY stayed high on every edge before that.
  task automatic wait_done(input int budget, output int edge_n, output logic busy_o);
    edge_n = -1;
    busy_o = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (DONE === 1'b1) begin
        edge_n = i;
        break;
      end
      if (BUSY !== 1'b1) busy_o = 1'b0;
    end
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    T     = 4'h0;
    tick();
    tick();
    check("rst_i_out", {24'h0, I_OUT}, 32'h00);
    check("rst_found", {31'h0, FOUND}, 32'h0);
    check("rst_done",  {31'h0, DONE},  32'h0);
    check("rst_busy",  {31'h0, BUSY},  32'h0);
    RESET = 1'b0;
    tick();

    // T=F: candidate 0x00 matches entries 2 and 7 -> class F
    START = 1'b1;
    T     = 4'hF;
    tick();
    check("a_busy_e0", {31'h0, BUSY}, 32'h1);
    check("a_done_e0", {31'h0, DONE}, 32'h0);
    wait_done(3000, n, busy_ok);
    check("a_edge",  n, 32'd9);
    check("a_found", {31'h0, FOUND}, 32'h1);
    check("a_i_out", {24'h0, I_OUT}, 32'h00);
    check("a_busy_done", {31'h0, BUSY}, 32'h0);
    START = 1'b0;
    tick();

    // T=4: candidate 0x01 matches only entry 7
    START = 1'b1;
    T     = 4'h4;
    tick();
    wait_done(3000, n, busy_ok);
    check("b_edge",  n, 32'd17);
    check("b_found", {31'h0, FOUND}, 32'h1);
    check("b_i_out", {24'h0, I_OUT}, 32'h01);
    check("b_busy",  {31'h0, busy_ok}, 32'h1);

    // Hold START high in DONE: nothing moves
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DONE !== 1'b1 || FOUND !== 1'b1 || I_OUT !== 8'h01 || BUSY !== 1'b0) stable_ok = 1'b0;
    end
    check("hs_stable", {31'h0, stable_ok}, 32'h1);
    START = 1'b0;
    tick();
    check("hs_done_clr", {31'h0, DONE},  32'h0);
    check("hs_found",    {31'h0, FOUND}, 32'h1);
    check("hs_i_out",    {24'h0, I_OUT}, 32'h01);
    tick();
    check("idle_i_out", {24'h0, I_OUT}, 32'h01);
    check("idle_busy",  {31'h0, BUSY},  32'h0);

    // T=0 with T changed to F just before E50; the latched target must win
    START = 1'b1;
    T     = 4'h0;
    tick();
    START = 1'b0;
    for (int i = 1; i <= 49; i++) tick();
    T = 4'hF;
    wait_done(3000, n, busy_ok);
    check("c_edge",  n + 49, 32'd137);
    check("c_found", {31'h0, FOUND}, 32'h1);
    check("c_i_out", {24'h0, I_OUT}, 32'h10);
    tick();

    // T=0 aborted by RESET at E60, then restarted with START held high
    START = 1'b1;
    T     = 4'h0;
    tick();
    for (int i = 1; i <= 59; i++) tick();
    check("d_busy_e59", {31'h0, BUSY}, 32'h1);
    RESET = 1'b1;
    tick();
    check("d_rst_busy",  {31'h0, BUSY},  32'h0);
    check("d_rst_done",  {31'h0, DONE},  32'h0);
    check("d_rst_found", {31'h0, FOUND}, 32'h0);
    check("d_rst_i_out", {24'h0, I_OUT}, 32'h00);
    RESET = 1'b0;
    T     = 4'h4;
    tick();
    check("d_busy_e0", {31'h0, BUSY}, 32'h1);
    wait_done(3000, n, busy_ok);
    check("d_edge",  n, 32'd17);
    check("d_i_out", {24'h0, I_OUT}, 32'h01);
    check("d_found", {31'h0, FOUND}, 32'h1);
    START = 1'b0;
    tick();

    // T=1 is unreachable: full sweep, BUSY high through E2048
    START = 1'b1;
    T     = 4'h1;
    tick();
    START = 1'b0;
    wait_done(2100, n, busy_ok);
    check("e_edge",  n, 32'd2049);
    check("e_busy",  {31'h0, busy_ok}, 32'h1);
    check("e_found", {31'h0, FOUND}, 32'h0);
    check("e_i_out", {24'h0, I_OUT}, 32'h00);
    check("e_done",  {31'h0, DONE},  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
